// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency memory.
// Alternates on ties, and services one read at a time through IDLE -> RD_WAIT -> RESP.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_last_grant;
    logic        r_owner;
    logic [31:0] r_addr;
    logic        r_if_rvalid;
    logic        r_d_rvalid;
    logic [63:0] r_if_rdata;
    logic [63:0] r_d_rdata;

    logic        w_idle;
    logic        w_gnt_if;
    logic        w_gnt_d;
    logic        w_any_gnt;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_gnt_addr;

    // Gating with rst keeps grants and the write strobe quiet while reset is held.
    assign w_idle     = rst && (r_state == IDLE);
    assign w_gnt_if   = w_idle && if_req && (!d_req || (r_last_grant == OWN_D));
    assign w_gnt_d    = w_idle && d_req && (!if_req || (r_last_grant == OWN_IF));
    assign w_any_gnt  = w_gnt_if || w_gnt_d;
    assign w_wr       = w_gnt_d && d_we;
    assign w_rd       = w_gnt_if || (w_gnt_d && !d_we);
    assign w_gnt_addr = w_gnt_d ? d_addr : if_addr;

    assign if_gnt    = w_gnt_if;
    assign d_gnt     = w_gnt_d;
    assign mem_addr  = w_any_gnt ? w_gnt_addr : r_addr;
    assign mem_wr    = w_wr;
    assign mem_wdata = w_wr ? d_wdata : 64'd0;
    assign busy      = (r_state != IDLE);
    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_last_grant <= OWN_IF;
            r_owner      <= OWN_IF;
            r_addr       <= 32'd0;
            r_if_rvalid  <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_if_rdata   <= 64'd0;
            r_d_rdata    <= 64'd0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_gnt) begin
                        r_last_grant <= w_gnt_d ? OWN_D : OWN_IF;
                        r_addr       <= w_gnt_addr;
                        if (w_rd) begin
                            r_state <= RD_WAIT;
                            r_cnt   <= 3'(MEM_LAT - 1);
                            r_owner <= w_gnt_d ? OWN_D : OWN_IF;
                        end
                    end
                end
                RD_WAIT: begin
                    // Counter hits zero in the last latency cycle; mem_rdata is valid at this edge.
                    if (r_cnt == 3'd0) begin
                        r_state <= RESP;
                        if (r_owner == OWN_D) begin
                            r_d_rdata  <= mem_rdata;
                            r_d_rvalid <= 1'b1;
                        end else begin
                            r_if_rdata  <= mem_rdata;
                            r_if_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-exact memory models, a read-data
// scoreboard queue, and a second instance exercising the one-cycle latency case.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr;
    logic [63:0] d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wr, busy;
    logic [63:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [31:0] mem_addr;

    logic        if_req1;
    logic [31:0] if_addr1;
    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_wr1, busy1;
    logic [63:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
    logic [31:0] mem_addr1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic [63:0] data;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(64'd0),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    function automatic logic [63:0] mdata(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Memory models: a read granted in cycle T drives valid data only across the
    // edge ending cycle T+LAT; any other capture edge sees BAD.
    logic        pv0 [0:2];
    logic [31:0] pa0 [0:2];
    logic        pv1 [0:1];
    logic [31:0] pa1 [0:1];

    initial begin
        for (int i = 0; i < 3; i++) begin pv0[i] = 1'b0; pa0[i] = 32'd0; end
        for (int i = 0; i < 2; i++) begin pv1[i] = 1'b0; pa1[i] = 32'd0; end
    end

    always @(negedge clk) begin
        pv0[0] <= (if_gnt | d_gnt) & ~mem_wr;
        pa0[0] <= mem_addr;
        pv0[1] <= pv0[0]; pa0[1] <= pa0[0];
        pv0[2] <= pv0[1]; pa0[2] <= pa0[1];
        pv1[0] <= if_gnt1;
        pa1[0] <= mem_addr1;
        pv1[1] <= pv1[0]; pa1[1] <= pa1[0];
    end

    assign mem_rdata  = pv0[2] ? mdata(pa0[2]) : BAD;
    assign mem_rdata1 = pv1[1] ? mdata(pa1[1]) : BAD;

    // Scoreboard consumer plus mutual-exclusion checks on the main instance.
    always @(negedge clk) begin
        exp_t e;
        chk("one_gnt", 64'(if_gnt & d_gnt), 64'd0);
        chk("one_rvalid", 64'(if_rvalid & d_rvalid), 64'd0);
        if (if_rvalid || d_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rv_port", 64'(d_rvalid), 64'(e.port));
                chk("rv_data", d_rvalid ? d_rdata : if_rdata, e.data);
            end
        end
    end

    initial begin
        logic exp_d, exp_if;
        rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h10; d_addr = 32'h20; d_wdata = 64'd0;
        if_req1 = 1'b0; if_addr1 = 32'd0;

        // Reset state with both requests high
        mid();
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_d_gnt", 64'(d_gnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        cyc(); rst = 1'b1; if_req = 1'b0; d_req = 1'b0;

        // Single fetch read, MEM_LAT=2
        cyc(); if_req = 1'b1; if_addr = 32'h40;
        mid();
        chk("rd_if_gnt", 64'(if_gnt), 64'd1);
        chk("rd_addr_t0", 64'(mem_addr), 64'h40);
        chk("rd_busy_t0", 64'(busy), 64'd0);
        exp_q.push_back('{1'b0, mdata(32'h40)});
        cyc(); if_req = 1'b0; mid();
        chk("rd_busy_t1", 64'(busy), 64'd1);
        chk("rd_addr_t1", 64'(mem_addr), 64'h40);
        chk("rd_if_gnt_t1", 64'(if_gnt), 64'd0);
        cyc(); mid();
        chk("rd_addr_t2", 64'(mem_addr), 64'h40);
        chk("rd_rvalid_t2", 64'(if_rvalid), 64'd0);
        cyc(); mid();
        chk("rd_rvalid_t3", 64'(if_rvalid), 64'd1);
        cyc(); mid();
        chk("rd_busy_t4", 64'(busy), 64'd0);
        chk("rd_rvalid_t4", 64'(if_rvalid), 64'd0);

        // Continuous contention: d, if, d, if every 4 cycles
        cyc(); if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h200; if_addr = 32'h300;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) cyc();
            mid();
            exp_d  = (c % 8 == 0);
            exp_if = (c % 8 == 4);
            if (exp_d)  exp_q.push_back('{1'b1, mdata(32'h200)});
            if (exp_if) exp_q.push_back('{1'b0, mdata(32'h300)});
            chk("tie_d_gnt", 64'(d_gnt), 64'(exp_d));
            chk("tie_if_gnt", 64'(if_gnt), 64'(exp_if));
        end
        cyc(); if_req = 1'b0; d_req = 1'b0;

        // Back-to-back writes
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            d_req = 1'b1; d_we = 1'b1;
            d_addr = 32'h100 + 32'(8 * i); d_wdata = 64'hDEAD + 64'(i);
            mid();
            chk("wr_d_gnt", 64'(d_gnt), 64'd1);
            chk("wr_mem_wr", 64'(mem_wr), 64'd1);
            chk("wr_mem_addr", 64'(mem_addr), 64'h100 + 64'(8 * i));
            chk("wr_mem_wdata", mem_wdata, 64'hDEAD + 64'(i));
            chk("wr_busy", 64'(busy), 64'd0);
        end
        cyc(); d_req = 1'b0; d_we = 1'b0; mid();
        chk("wr_done_mem_wr", 64'(mem_wr), 64'd0);
        chk("wr_done_wdata", mem_wdata, 64'd0);

        // Fetch request arriving during a data read waits for IDLE
        cyc(); d_req = 1'b1; d_addr = 32'h500; mid();
        chk("wait_d_gnt", 64'(d_gnt), 64'd1);
        exp_q.push_back('{1'b1, mdata(32'h500)});
        cyc(); d_req = 1'b0; if_req = 1'b1; if_addr = 32'h600;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) cyc();
            mid();
            chk("wait_if_gnt_low", 64'(if_gnt), 64'd0);
        end
        chk("wait_d_rvalid", 64'(d_rvalid), 64'd1);
        cyc(); mid();
        chk("wait_if_gnt", 64'(if_gnt), 64'd1);
        exp_q.push_back('{1'b0, mdata(32'h600)});
        cyc(); if_req = 1'b0;
        cyc(); cyc(); cyc(); mid();
        chk("wait_busy_done", 64'(busy), 64'd0);

        // Reset in the middle of a data read
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; mid();
        chk("rr_d_gnt", 64'(d_gnt), 64'd1);
        cyc(); d_req = 1'b0; rst = 1'b0; #1;
        chk("rr_busy", 64'(busy), 64'd0);
        chk("rr_mem_addr", 64'(mem_addr), 64'd0);
        chk("rr_d_rdata", d_rdata, 64'd0);
        chk("rr_if_rdata", if_rdata, 64'd0);
        chk("rr_gnt", 64'({if_gnt, d_gnt}), 64'd0);
        chk("rr_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        cyc(); cyc();
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h800; mid();
        chk("rr_first_gnt", 64'(if_gnt), 64'd1);
        exp_q.push_back('{1'b0, mdata(32'h800)});
        cyc(); if_req = 1'b0;
        cyc(); cyc(); cyc(); mid();
        chk("rr_busy_done", 64'(busy), 64'd0);
        chk("q_empty", 64'(exp_q.size()), 64'd0);

        // MEM_LAT=1 instance: rvalid exactly two cycles after grant
        cyc(); if_req1 = 1'b1; if_addr1 = 32'h900; mid();
        chk("l1_gnt", 64'(if_gnt1), 64'd1);
        cyc(); if_req1 = 1'b0; mid();
        chk("l1_rvalid_t1", 64'(if_rvalid1), 64'd0);
        chk("l1_busy_t1", 64'(busy1), 64'd1);
        cyc(); mid();
        chk("l1_rvalid_t2", 64'(if_rvalid1), 64'd1);
        chk("l1_rdata_t2", if_rdata1, mdata(32'h900));
        chk("l1_d_rvalid", 64'(d_rvalid1), 64'd0);
        cyc(); mid();
        chk("l1_rvalid_t3", 64'(if_rvalid1), 64'd0);
        chk("l1_busy_t3", 64'(busy1), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, meaning memory read latency in cycles from address presented to mem_rdata valid; legal range 1..7.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch read request; if_addr input 32, fetch address.
REQ-005 if_gnt  output  1  fetch request accepted; if_rvalid output 1, fetch data valid; if_rdata output 64, fetch read data.
REQ-006 d_req  input  1  data request; d_we input 1, 1=write; d_addr input 32; d_wdata input 64.
REQ-007 d_gnt  output  1  data request accepted; d_rvalid output 1, data read valid; d_rdata output 64, data read data.
REQ-008 mem_addr  output  32; mem_wdata output 64; mem_wr output 1, write strobe; mem_rdata input 64.
REQ-009 busy  output  1  high when state is not IDLE.

Function
REQ-010 FSM states IDLE, RD_WAIT, RESP; grants SHALL issue only in IDLE.
REQ-011 In IDLE with exactly one req high, that requester SHALL be granted in the same cycle (gnt combinational from state and req).
REQ-012 In IDLE with both req high, the requester other than last_grant SHALL be granted; last_grant resets to fetch, so data wins the first tie.
REQ-013 last_grant SHALL update on every grant, read or write.
REQ-014 gnt SHALL be a single-cycle pulse; at most one of if_gnt/d_gnt high per cycle.
REQ-015 In the grant cycle, mem_addr SHALL equal the granted address; the address SHALL be registered and held on mem_addr through RD_WAIT.
REQ-016 Data write grant (d_we=1): mem_wr=1 and mem_wdata=d_wdata in the grant cycle only; FSM stays IDLE; no rvalid issued.
REQ-017 Read grant at cycle T: FSM to RD_WAIT, counter loaded MEM_LAT-1; mem_rdata captured at the edge ending cycle T+MEM_LAT; FSM to RESP.
REQ-018 In RESP (cycle T+MEM_LAT+1), the owner's rvalid SHALL be high exactly one cycle with rdata = captured word; FSM to IDLE next cycle.
REQ-019 if_rdata and d_rdata SHALL hold the last captured value until the next capture; the non-owner's rvalid stays 0.
REQ-020 mem_wr SHALL be 0 in every cycle other than a write-grant cycle.
REQ-021 A req dropped before grant SHALL have no effect; a req high in IDLE is always a new request.
REQ-022 Requests arriving in RD_WAIT or RESP SHALL wait, not be dropped or queued internally; arbitration in IDLE resolves them.
REQ-023 Back-to-back writes SHALL be accepted one per cycle; read throughput SHALL be one per MEM_LAT+2 cycles.
REQ-024 MEM_LAT=1: capture at the edge ending T+1, rvalid in T+2.

Reset
REQ-025 rst low SHALL immediately force IDLE, counter 0, last_grant=fetch, all gnt/rvalid/mem_wr/busy 0, mem_addr/mem_wdata/if_rdata/d_rdata 0.
REQ-026 Reset during RD_WAIT or RESP SHALL discard the pending read; no rvalid after release.
REQ-027 First grant possible in the first cycle after rst deasserts.

Verification
REQ-028 MEM_LAT=2, if_req only, if_addr=0x40 at T -> if_gnt T, mem_addr=0x40 T..T+2, mem_rdata=0xA5 at T+2, if_rvalid T+3 with if_rdata=0xA5, busy low T+4.
REQ-029 Both req high continuously (data reads) -> grant order d,if,d,if; each grant 4 cycles apart; never both gnt.
REQ-030 d_req,d_we=1, addr 0x100, wdata 0xDEAD for 3 cycles (new addr each) -> d_gnt and mem_wr high 3 consecutive cycles, busy stays 0.
REQ-031 d_req read granted at T, rst low at T+1 -> all outputs 0 at once; after release no d_rvalid; if_req then granted in first cycle.
REQ-032 if_req asserted during data RD_WAIT -> no if_gnt until IDLE; granted in the IDLE cycle after d_rvalid.
REQ-033 MEM_LAT=1 single read -> rvalid exactly two cycles after gnt.
